// File: rtl/instr_sequencer.sv
// Instruction store, playback FSM and step timer: saves up to DEPTH instructions and replays them in order.
// Each instruction is held for STEP_CYCLES clocks. Define SEQ_PAUSE_EN to add the pause input and the PAUSED state.
module instr_sequencer #(
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 8,
  parameter int STEP_CYCLES = 50000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       save,
  input  logic                       execute,
  input  logic                       clear,
  input  logic                       del,
  input  logic                       loop_mode,
`ifdef SEQ_PAUSE_EN
  input  logic                       pause,
`endif
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       active,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(STEP_CYCLES + 1);
  localparam logic [TW-1:0] TERM = TW'(STEP_CYCLES - 1);

`ifdef SEQ_PAUSE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

  state_t            state, state_nxt;
  logic [CW-1:0]     count_nxt;
  logic [IW-1:0]     step_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic              done_nxt;
  logic              mem_we;
  logic [CW-1:0]     last_idx;
  logic              is_last;
  logic [DATA_W-1:0] mem [DEPTH];

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign last_idx = count - 1'b1;
  assign is_last  = ({1'b0, step_idx} == last_idx);
  assign active   = (state != S_IDLE);
  // The program cannot change outside IDLE, so reading memory directly is stable during playback.
  assign data_out = (state == S_IDLE) ? '0 : mem[step_idx];

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    step_nxt  = step_idx;
    timer_nxt = timer;
    done_nxt  = 1'b0;
    mem_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear) begin
          count_nxt = '0;
        end else if (del) begin
          if (!empty) count_nxt = count - 1'b1;
        end else if (save) begin
          if (!full) begin
            mem_we    = 1'b1;
            count_nxt = count + 1'b1;
          end
        end else if (execute && !empty) begin
          state_nxt = S_RUN;
          step_nxt  = '0;
          timer_nxt = '0;
        end
      end
      S_RUN: begin
        if (execute) begin
          state_nxt = S_IDLE;
          step_nxt  = '0;
          timer_nxt = '0;
`ifdef SEQ_PAUSE_EN
        end else if (pause) begin
          state_nxt = S_PAUSED;
`endif
        end else if (timer == TERM) begin
          timer_nxt = '0;
          if (!is_last) begin
            step_nxt = step_idx + 1'b1;
          end else if (loop_mode) begin
            step_nxt = '0;
          end else begin
            state_nxt = S_IDLE;
            step_nxt  = '0;
            done_nxt  = 1'b1;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
`ifdef SEQ_PAUSE_EN
      // Timer, step and output are simply left untouched while paused.
      S_PAUSED: begin
        if (execute) begin
          state_nxt = S_IDLE;
          step_nxt  = '0;
          timer_nxt = '0;
        end else if (pause) begin
          state_nxt = S_RUN;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      step_idx <= '0;
      timer    <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      step_idx <= step_nxt;
      timer    <= timer_nxt;
      done     <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[count[IW-1:0]] <= data_in;
  end

endmodule
